// File: rtl/isa_decoder_pipe_if.sv
// Instruction stream in, decoded beat stream out, for isa_decoder_pipe.
`timescale 1ns/1ps
interface isa_decoder_pipe_if #(
   parameter int unsigned DWIDTH_INST  = 32,
   parameter int unsigned DWIDTH_RFADD = 5,
   parameter int unsigned DWIDTH_INT   = 32,
   parameter int unsigned LANES        = 4,
   parameter int unsigned VLMAX        = 32
);
   localparam int unsigned VL_W = $clog2(VLMAX + 1);

   logic [DWIDTH_INST-1:0]  instr;
   logic                    instr_tvalid;
   logic                    instr_tready;
   logic                    out_tvalid;
   logic                    out_tready;
   logic [DWIDTH_RFADD-1:0] rs1;
   logic [DWIDTH_RFADD-1:0] rs2;
   logic [DWIDTH_RFADD-1:0] rd;
   logic [DWIDTH_RFADD-1:0] vr_addr;
   logic [DWIDTH_RFADD-1:0] vw_addr;
   logic                    is_vle32_vv;
   logic                    is_vse32_vv;
   logic                    is_vmacc_vv;
   logic                    is_vstreamout;
   logic                    is_bne;
   logic                    is_csr;
   logic                    is_lw;
   logic                    is_lui;
   logic                    is_addi;
   logic                    is_illegal;
   logic                    is_not_vect;
   logic [2:0]              op;
   logic [2:0]              op_scalar;
   logic [11:0]             branch_immediate;
   logic [DWIDTH_INT-1:0]   R_immediate;
   logic                    wen_RF_scalar;
   logic [LANES-1:0]        lane_mask;
   logic                    beat_last;
   logic [VL_W-1:0]         vl;

   modport master (
      output instr, instr_tvalid, out_tready,
      input  instr_tready, out_tvalid, rs1, rs2, rd, vr_addr, vw_addr,
      input  is_vle32_vv, is_vse32_vv, is_vmacc_vv, is_vstreamout, is_bne, is_csr,
      input  is_lw, is_lui, is_addi, is_illegal, is_not_vect, op, op_scalar,
      input  branch_immediate, R_immediate, wen_RF_scalar, lane_mask, beat_last, vl
   );

   modport slave (
      input  instr, instr_tvalid, out_tready,
      output instr_tready, out_tvalid, rs1, rs2, rd, vr_addr, vw_addr,
      output is_vle32_vv, is_vse32_vv, is_vmacc_vv, is_vstreamout, is_bne, is_csr,
      output is_lw, is_lui, is_addi, is_illegal, is_not_vect, op, op_scalar,
      output branch_immediate, R_immediate, wen_RF_scalar, lane_mask, beat_last, vl
   );
endinterface

// File: rtl/isa_decoder_pipe.sv
// Decodes one instruction per handshake and expands vector ops into
// ceil(vl/LANES) lane beats; vsetivli updates the live vector length.
`timescale 1ns/1ps
module isa_decoder_pipe #(
   parameter int unsigned DWIDTH_INST  = 32,
   parameter int unsigned DWIDTH_RFADD = 5,
   parameter int unsigned DWIDTH_INT   = 32,
   parameter int unsigned LANES        = 4,
   parameter int unsigned VLMAX        = 32
) (
   input logic clk,
   input logic rst,
   isa_decoder_pipe_if.slave bus
);
   localparam int unsigned VL_W    = $clog2(VLMAX + 1);
   localparam int unsigned FLAG_W  = 10;
   localparam int unsigned F_VLE   = 0;
   localparam int unsigned F_VSE   = 1;
   localparam int unsigned F_VMACC = 2;
   localparam int unsigned F_VSO   = 3;
   localparam int unsigned F_BNE   = 4;
   localparam int unsigned F_CSR   = 5;
   localparam int unsigned F_LW    = 6;
   localparam int unsigned F_LUI   = 7;
   localparam int unsigned F_ADDI  = 8;
   localparam int unsigned F_ILL   = 9;

   logic [DWIDTH_INST-1:0] ins;
   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic [FLAG_W-1:0]      d_flags;
   logic                   d_vec;
   logic [2:0]             d_op;
   logic [2:0]             d_op_scalar;
   logic [DWIDTH_INT-1:0]  d_imm;
   logic [VL_W-1:0]        d_vl;
   logic                   d_wen;

   logic [VL_W-1:0]        vl_q;
   logic [VL_W-1:0]        bcnt;
   logic                   expanding;
   logic                   out_valid;
   logic                   ready_en;
   logic [FLAG_W-1:0]      flags;
   logic                   not_vect;

   int unsigned            vl_u;
   int unsigned            last_idx;
   int unsigned            tail_cnt;
   logic [LANES-1:0]       tail_mask;
   logic                   first_last;
   logic                   next_last;
   logic                   accept;
   logic                   fire;

   assign ins    = bus.instr;
   assign opcode = ins[6:0];
   assign funct3 = ins[14:12];

   // Instruction class, immediates and candidate new vl for the incoming word
   always_comb begin
      d_flags     = '0;
      d_op        = '0;
      d_op_scalar = '0;
      d_imm       = '0;
      d_vl        = '0;
      d_wen       = 1'b0;
      case (opcode)
         7'b1010111: begin
            if (funct3 == 3'b111 && ins[31:30] == 2'b11) d_flags[F_CSR] = 1'b1;
            else                                         d_flags[F_VMACC] = 1'b1;
         end
         7'b0000111: d_flags[F_VLE]  = 1'b1;
         7'b0100111: d_flags[F_VSE]  = 1'b1;
         7'b1111111: d_flags[F_VSO]  = 1'b1;
         7'b0000011: d_flags[F_LW]   = 1'b1;
         7'b0110111: d_flags[F_LUI]  = 1'b1;
         7'b0010011: d_flags[F_ADDI] = 1'b1;
         7'b1100011: d_flags[F_BNE]  = 1'b1;
         default:    d_flags[F_ILL]  = 1'b1;
      endcase
      d_vec = d_flags[F_VLE] | d_flags[F_VSE] | d_flags[F_VMACC];
      if (d_vec | d_flags[F_VSO] | d_flags[F_CSR])
         d_op = funct3;
      if (d_flags[F_BNE] | d_flags[F_LW] | d_flags[F_LUI] | d_flags[F_ADDI])
         d_op_scalar = funct3;
      if (32'(ins[19:15]) > VLMAX) d_vl = VL_W'(VLMAX);
      else                         d_vl = VL_W'(ins[19:15]);
      if (d_flags[F_LW] | d_flags[F_ADDI]) d_imm = DWIDTH_INT'($signed(ins[31:20]));
      if (d_flags[F_LUI])                  d_imm = DWIDTH_INT'({ins[31:12], 12'h000});
      if (d_flags[F_CSR])                  d_imm = DWIDTH_INT'(d_vl);
      d_wen = (d_flags[F_LW] | d_flags[F_LUI] | d_flags[F_ADDI] | d_flags[F_CSR])
              && (ins[11:7] != 5'd0);
   end

   // Final-beat index and partial lane mask for the current vl (unused when vl==0)
   always_comb begin
      vl_u       = 32'(vl_q);
      last_idx   = (vl_u - 32'd1) / LANES;
      tail_cnt   = ((vl_u - 32'd1) % LANES) + 32'd1;
      tail_mask  = LANES'((32'd1 << tail_cnt) - 32'd1);
      first_last = (last_idx == 32'd0);
      next_last  = ((32'(bcnt) + 32'd1) == last_idx);
   end

   assign bus.instr_tready = ready_en && !expanding && (!out_valid || bus.out_tready);
   assign accept           = bus.instr_tvalid && bus.instr_tready;
   assign fire             = out_valid && bus.out_tready;

   assign bus.out_tvalid    = out_valid;
   assign bus.vl            = vl_q;
   assign bus.is_not_vect   = not_vect;
   assign bus.is_vle32_vv   = flags[F_VLE];
   assign bus.is_vse32_vv   = flags[F_VSE];
   assign bus.is_vmacc_vv   = flags[F_VMACC];
   assign bus.is_vstreamout = flags[F_VSO];
   assign bus.is_bne        = flags[F_BNE];
   assign bus.is_csr        = flags[F_CSR];
   assign bus.is_lw         = flags[F_LW];
   assign bus.is_lui        = flags[F_LUI];
   assign bus.is_addi       = flags[F_ADDI];
   assign bus.is_illegal    = flags[F_ILL];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en             <= 1'b0;
         out_valid            <= 1'b0;
         expanding            <= 1'b0;
         bcnt                 <= '0;
         vl_q                 <= VL_W'(VLMAX);
         flags                <= '0;
         not_vect             <= 1'b0;
         bus.rs1              <= '0;
         bus.rs2              <= '0;
         bus.rd               <= '0;
         bus.vr_addr          <= '0;
         bus.vw_addr          <= '0;
         bus.op               <= '0;
         bus.op_scalar        <= '0;
         bus.branch_immediate <= '0;
         bus.R_immediate      <= '0;
         bus.wen_RF_scalar    <= 1'b0;
         bus.lane_mask        <= '0;
         bus.beat_last        <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            bus.rs1              <= DWIDTH_RFADD'(ins[19:15]);
            bus.rs2              <= DWIDTH_RFADD'(ins[24:20]);
            bus.rd               <= DWIDTH_RFADD'(ins[11:7]);
            bus.vr_addr          <= DWIDTH_RFADD'(ins[19:15]);
            bus.vw_addr          <= DWIDTH_RFADD'(ins[11:7]);
            bus.op               <= d_op;
            bus.op_scalar        <= d_op_scalar;
            bus.branch_immediate <= {ins[31], ins[7], ins[30:25], ins[11:8]};
            bus.R_immediate      <= d_imm;
            bcnt                 <= '0;
            if (d_flags[F_CSR]) vl_q <= d_vl;
            if (d_vec && vl_q == '0) begin
               // Empty vector op: swallowed with no beat
               out_valid         <= 1'b0;
               expanding         <= 1'b0;
               flags             <= '0;
               not_vect          <= 1'b0;
               bus.wen_RF_scalar <= 1'b0;
               bus.beat_last     <= 1'b0;
               bus.lane_mask     <= '0;
            end else if (d_vec) begin
               out_valid         <= 1'b1;
               expanding         <= !first_last;
               flags             <= d_flags;
               not_vect          <= 1'b0;
               bus.wen_RF_scalar <= 1'b0;
               bus.beat_last     <= first_last;
               bus.lane_mask     <= first_last ? tail_mask : '1;
            end else begin
               out_valid         <= 1'b1;
               expanding         <= 1'b0;
               flags             <= d_flags;
               not_vect          <= 1'b1;
               bus.wen_RF_scalar <= d_wen;
               bus.beat_last     <= 1'b1;
               bus.lane_mask     <= '1;
            end
         end else if (fire) begin
            if (expanding) begin
               bcnt          <= bcnt + VL_W'(1);
               bus.vr_addr   <= bus.vr_addr + DWIDTH_RFADD'(1);
               bus.vw_addr   <= bus.vw_addr + DWIDTH_RFADD'(1);
               bus.beat_last <= next_last;
               bus.lane_mask <= next_last ? tail_mask : '1;
               expanding     <= !next_last;
            end else begin
               out_valid         <= 1'b0;
               flags             <= '0;
               not_vect          <= 1'b0;
               bus.wen_RF_scalar <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_isa_decoder_pipe.sv
// Randomized and directed bench for isa_decoder_pipe against a beat-queue reference model.
`timescale 1ns/1ps
module tb_isa_decoder_pipe;
   localparam int unsigned LANES = 4;
   localparam int unsigned VLMAX = 32;

   typedef struct packed {
      logic [9:0]  fl;   // {illegal,addi,lui,lw,csr,bne,vso,vmacc,vse,vle}
      logic        nv;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [4:0]  vr;
      logic [4:0]  vw;
      logic [2:0]  op;
      logic [2:0]  ops;
      logic [11:0] bi;
      logic [31:0] ri;
      logic        wen;
      logic [3:0]  mask;
      logic        last;
      logic [5:0]  vl;
   } beat_t;

   localparam logic [31:0] CSR16 = 32'b1_1_0011001100_10000_111_01111_1010111;
   localparam logic [31:0] VALU  = 32'b001101_0_11000_01000_000_10111_1010111;
   localparam logic [31:0] CSR6  = {2'b11, 10'd0, 5'd6, 3'b111, 5'd0, 7'b1010111};
   localparam logic [31:0] CSR0  = {2'b11, 10'd0, 5'd0, 3'b111, 5'd1, 7'b1010111};
   localparam logic [31:0] VLE   = {12'd0, 5'd2, 3'b110, 5'd3, 7'b0000111};
   localparam logic [31:0] ADDI  = 32'b001100110011_11011_000_00100_0010011;
   localparam logic [31:0] LUI   = {20'hCCCCC, 5'd8, 7'b0110111};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   isa_decoder_pipe_if bus ();
   isa_decoder_pipe dut (.clk(clk), .rst(rst), .bus(bus));

   int          checks = 0;
   int          failures = 0;
   beat_t       mq[$];
   logic [31:0] stim[$];
   logic        rscript[$];
   int          model_vl = VLMAX;
   bit          rand_mode = 1'b0;
   bit          acc_last = 1'b0;
   int          beats_seen = 0;
   beat_t       last_obs;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic beat_t obs();
      beat_t o;
      o.fl   = {bus.is_illegal, bus.is_addi, bus.is_lui, bus.is_lw, bus.is_csr, bus.is_bne,
                bus.is_vstreamout, bus.is_vmacc_vv, bus.is_vse32_vv, bus.is_vle32_vv};
      o.nv   = bus.is_not_vect;
      o.rs1  = bus.rs1;
      o.rs2  = bus.rs2;
      o.rd   = bus.rd;
      o.vr   = bus.vr_addr;
      o.vw   = bus.vw_addr;
      o.op   = bus.op;
      o.ops  = bus.op_scalar;
      o.bi   = bus.branch_immediate;
      o.ri   = bus.R_immediate;
      o.wen  = bus.wen_RF_scalar;
      o.mask = bus.lane_mask;
      o.last = bus.beat_last;
      o.vl   = bus.vl;
      return o;
   endfunction

   // Reference: list every beat an accepted instruction must produce
   function automatic void model_accept(input logic [31:0] i);
      beat_t b;
      int    cls;
      int    n;
      b     = '0;
      b.rs1 = i[19:15];
      b.rs2 = i[24:20];
      b.rd  = i[11:7];
      b.bi  = {i[31], i[7], i[30:25], i[11:8]};
      case (i[6:0])
         7'b1010111: cls = (i[14:12] == 3'b111 && i[31:30] == 2'b11) ? 5 : 2;
         7'b0000111: cls = 0;
         7'b0100111: cls = 1;
         7'b1111111: cls = 3;
         7'b1100011: cls = 4;
         7'b0000011: cls = 6;
         7'b0110111: cls = 7;
         7'b0010011: cls = 8;
         default:    cls = 9;
      endcase
      b.fl = 10'd1 << cls;
      if (cls <= 3 || cls == 5) b.op = i[14:12];
      if (cls == 4 || (cls >= 6 && cls <= 8)) b.ops = i[14:12];
      if (cls == 5) begin
         model_vl = (int'(i[19:15]) > VLMAX) ? VLMAX : int'(i[19:15]);
         b.ri = 32'(model_vl);
      end
      if (cls == 6 || cls == 8) b.ri = {{20{i[31]}}, i[31:20]};
      if (cls == 7) b.ri = {i[31:12], 12'h000};
      b.wen = (cls >= 5 && cls <= 8) && (i[11:7] != 5'd0);
      b.vl  = 6'(model_vl);
      if (cls <= 2) begin
         n = (model_vl + LANES - 1) / LANES;
         for (int k = 0; k < n; k++) begin
            b.vr   = 5'(int'(i[19:15]) + k);
            b.vw   = 5'(int'(i[11:7]) + k);
            b.last = (k == n - 1);
            b.mask = b.last ? 4'((1 << (((model_vl - 1) % LANES) + 1)) - 1) : 4'hF;
            b.nv   = 1'b0;
            mq.push_back(b);
         end
      end else begin
         b.vr   = b.rs1;
         b.vw   = b.rd;
         b.mask = 4'hF;
         b.last = 1'b1;
         b.nv   = 1'b1;
         mq.push_back(b);
      end
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[6:0] = 7'b0000111;
         1: r[6:0] = 7'b0100111;
         2: r[6:0] = 7'b1010111;
         3: r[6:0] = 7'b1111111;
         4: r[6:0] = 7'b1100011;
         5: begin r[31:30] = 2'b11; r[14:12] = 3'b111; r[6:0] = 7'b1010111; end
         6: r[6:0] = 7'b0000011;
         7: r[6:0] = 7'b0110111;
         8: r[6:0] = 7'b0010011;
         default: ;
      endcase
      return r;
   endfunction

   // One clock: drive at negedge, sample 1ns later, model the coming posedge
   task automatic cycle();
      beat_t o;
      @(negedge clk);
      if (acc_last) begin
         bus.instr_tvalid = 1'b0;
         acc_last = 1'b0;
      end
      if (!bus.instr_tvalid && stim.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
         bus.instr = stim.pop_front();
         bus.instr_tvalid = 1'b1;
      end
      if (rscript.size() > 0) bus.out_tready = rscript.pop_front();
      else if (rand_mode)     bus.out_tready = 1'($urandom_range(0, 1));
      else                    bus.out_tready = 1'b1;
      #1;
      o = obs();
      check("out_tvalid", bus.out_tvalid, mq.size() > 0);
      check("instr_tready", bus.instr_tready, (mq.size() <= 1) && (!bus.out_tvalid || bus.out_tready));
      check("vl", bus.vl, model_vl);
      if (bus.out_tvalid && mq.size() > 0) begin
         check($sformatf("beat%0d", beats_seen), o, mq[0]);
         if (bus.out_tready) begin
            last_obs = o;
            void'(mq.pop_front());
            beats_seen++;
         end
      end else if (!bus.out_tvalid) begin
         check("idle_flags", {o.fl, o.nv}, 0);
      end
      if (bus.instr_tvalid && bus.instr_tready) begin
         model_accept(bus.instr);
         acc_last = 1'b1;
      end
   endtask

   task automatic run(input int maxc);
      int n;
      n = 0;
      while ((stim.size() > 0 || (bus.instr_tvalid && !acc_last) || mq.size() > 0) && n < maxc) begin
         cycle();
         n++;
      end
      check("drain_left", stim.size() + mq.size(), 0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t r;
      int    base;
      int    n;
      rst = 1'b1;
      bus.instr = '0;
      bus.instr_tvalid = 1'b0;
      bus.out_tready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      r = '0;
      r.vl = 6'(VLMAX);
      check("rst_outputs", obs(), r);
      check("rst_tvalid", bus.out_tvalid, 0);
      check("rst_tready", bus.instr_tready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("tready_before_edge", bus.instr_tready, 0);
      @(posedge clk);
      #1;
      check("tready_after_edge", bus.instr_tready, 1);
      bus.out_tready = 1'b1;

      base = beats_seen;
      stim.push_back(CSR16);
      run(50);
      check("csr16_beats", beats_seen - base, 1);
      check("csr16_rimm", last_obs.ri, 16);
      check("csr16_rd", last_obs.rd, 15);
      check("csr16_wen", last_obs.wen, 1);
      check("csr16_is_csr", last_obs.fl, 10'b0000100000);

      base = beats_seen;
      stim.push_back(VALU);
      run(50);
      check("valu_beats", beats_seen - base, 4);
      check("valu_last_vr", last_obs.vr, 11);
      check("valu_last_vw", last_obs.vw, 26);
      check("valu_last_mask", last_obs.mask, 4'b1111);

      base = beats_seen;
      stim.push_back(CSR6);
      stim.push_back(VLE);
      run(50);
      check("vle6_beats", beats_seen - base, 3);
      check("vle6_tail_mask", last_obs.mask, 4'b0011);

      base = beats_seen;
      stim.push_back(CSR0);
      stim.push_back(VALU);
      run(50);
      check("vl0_beats", beats_seen - base, 1);
      check("vl0_vl", bus.vl, 0);

      stim.push_back(ADDI);
      run(50);
      check("addi_rimm", last_obs.ri, 819);
      check("addi_rs1", last_obs.rs1, 27);
      check("addi_rd", last_obs.rd, 4);
      stim.push_back(LUI);
      run(50);
      check("lui_rimm", last_obs.ri, 32'hCCCCC000);

      // Three-cycle stall on beat 2 of 4
      stim.push_back(CSR16);
      run(50);
      base = beats_seen;
      rscript = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      stim.push_back(VALU);
      run(50);
      check("stall_beats", beats_seen - base, 4);

      // Reset while beat 2 of 4 is on the bus
      base = beats_seen;
      stim.push_back(VALU);
      n = 0;
      while (beats_seen - base < 1 && n < 50) begin
         cycle();
         n++;
      end
      check("rstmid_reach", beats_seen - base, 1);
      @(posedge clk);
      #2;
      check("rstmid_beat2_valid", bus.out_tvalid, mq.size() > 0);
      rst = 1'b1;
      #1;
      check("rstmid_tvalid", bus.out_tvalid, 0);
      check("rstmid_tready", bus.instr_tready, 0);
      mq.delete();
      model_vl = VLMAX;
      bus.instr_tvalid = 1'b0;
      acc_last = 1'b0;
      check("rstmid_vl", bus.vl, model_vl);
      @(negedge clk);
      rst = 1'b0;
      base = beats_seen;
      stim.push_back(ADDI);
      run(50);
      check("rstmid_next_beats", beats_seen - base, 1);
      check("rstmid_next_is_addi", last_obs.fl, 10'b0100000000);

      rand_mode = 1'b1;
      for (int k = 0; k < 300; k++) stim.push_back(rand_instr());
      run(20000);
      rand_mode = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
